// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: bus request and
// response structs, the decode-facing fetch word, the FSM state encoding and
// the instruction buffer entry layout.
package fetch_unit_pkg;

    // Reset value of the fetch program counter.
    localparam logic [63:0] PCINIT  = 64'h8000_0000;
    // Sequential fetch stride (one 32-bit instruction).
    localparam logic [63:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        is_bubble;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    // One captured instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } buf_entry_t;

    // Sequential successor of a fetch address; wraps modulo 2^64.
    function automatic logic [63:0] next_pc(input logic [63:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small instruction buffer (1 or 2 entries) holding words fetched while decode
// is stalled. Entry 0 is always the head; a pop shifts the younger entry down,
// and a push may coincide with a pop.
module fetch_buf #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 96,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] entry_val [DEPTH];

    // Pops of an empty buffer and pushes into a full one are ignored, except
    // that a full buffer accepts a push in the same cycle it is popped.
    assign do_pop  = pop & (count_reg != '0);
    assign do_push = push & ((count_reg != CNT_W'(DEPTH)) | do_pop);
    // The new word lands just behind the surviving entries.
    assign wr_idx  = do_pop ? (count_reg - CNT_W'(1)) : count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            logic [WIDTH-1:0] shifted;

            if (gi + 1 < DEPTH) begin : g_shift
                assign shifted = do_pop ? entry_val[gi + 1] : data_reg;
            end else begin : g_last
                assign shifted = data_reg;
            end

            // Entry storage: take the pushed word when addressed, else shift.
            always_ff @(posedge clk) begin
                if (do_push && (wr_idx == CNT_W'(gi))) begin
                    data_reg <= push_data;
                end else begin
                    data_reg <= shifted;
                end
            end

            assign entry_val[gi] = data_reg;
        end
    endgenerate

    // Occupancy update; flush empties the buffer regardless of push/pop.
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign head  = entry_val[0];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches on the instruction bus,
// delivers one registered word per cycle to decode, parks words in fetch_buf
// while decode stalls, and follows taken-branch redirects (waiting out an
// in-flight request in DISCARD).
// Optional feature: define FETCH_PREFETCH_EN to keep fetching while held,
// using a 2-entry buffer so the word after the held one needs no new bus
// round trip once the stall releases.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF
);

`ifdef FETCH_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int BUF_W     = $bits(buf_entry_t);

    fetch_state_t   state_reg;
    fetch_state_t   state_next;
    logic [63:0]    pc_reg;
    logic [63:0]    pc_next;
    logic [63:0]    target_reg;
    logic [63:0]    target_next;
    fetch_data_t    data_f_reg;
    fetch_data_t    data_f_next;
    logic           req_en_reg;

    logic           req_valid;
    logic           accept;
    logic           redir;
    logic           buf_push;
    logic           buf_pop;
    logic           buf_flush;
    buf_entry_t     buf_din;
    logic [BUF_W-1:0]     buf_head;
    logic [BUF_CNT_W-1:0] buf_count;
    buf_entry_t     head_entry;
    logic           unused_addr_ok;

    // Address acceptance is not needed: the request stays up until data_ok.
    assign unused_addr_ok = iresp.addr_ok;

    assign redir      = redirect_valid & ~stall;
    assign accept     = req_valid & iresp.data_ok;
    assign head_entry = buf_head;
    assign buf_din    = '{instr: iresp.data, pc: pc_reg};

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (BUF_W),
        .CNT_W (BUF_CNT_W)
    ) u_fetch_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data (buf_din),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .head      (buf_head),
        .count     (buf_count)
    );

    // Bus request: always for pc_reg; DISCARD keeps the abandoned address up
    // until its data returns. Nothing is requested in the cycle reset is live.
    always_comb begin
        req_valid = 1'b0;
        case (state_reg)
            FETCH, DISCARD: req_valid = req_en_reg;
`ifdef FETCH_PREFETCH_EN
            HOLD:           req_valid = req_en_reg & (buf_count != BUF_CNT_W'(BUF_DEPTH));
`else
            HOLD:           req_valid = 1'b0;
`endif
            default:        req_valid = 1'b0;
        endcase
    end

    assign ireq  = '{valid: req_valid, addr: pc_reg};
    assign dataF = data_f_reg;

    // Next-state, pc and decode-word selection.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        target_next = target_reg;
        data_f_next = data_f_reg;
        buf_push    = 1'b0;
        buf_pop     = 1'b0;
        buf_flush   = 1'b0;

        // Decode consumed the last word and nothing new arrives: bubble.
        // A stalled decode keeps seeing the same word.
        if (!stall) begin
            data_f_next.is_bubble = 1'b1;
        end

        case (state_reg)
            FETCH: begin
                if (redir) begin
                    if (req_valid && !iresp.data_ok) begin
                        target_next = redirect_pc;
                        state_next  = DISCARD;
                    end else begin
                        pc_next = redirect_pc;
                    end
                end else if (accept) begin
                    pc_next = next_pc(pc_reg);
                    if (stall) begin
                        buf_push   = 1'b1;
                        state_next = HOLD;
                    end else begin
                        data_f_next = '{raw_instr: iresp.data, pc: pc_reg, is_bubble: 1'b0};
                    end
                end
            end

            DISCARD: begin
                if (accept) begin
                    pc_next    = redir ? redirect_pc : target_reg;
                    state_next = FETCH;
                end else if (redir) begin
                    target_next = redirect_pc;
                end
            end

            HOLD: begin
                if (redir) begin
                    buf_flush = 1'b1;
                    if (req_valid && !iresp.data_ok) begin
                        target_next = redirect_pc;
                        state_next  = DISCARD;
                    end else begin
                        pc_next    = redirect_pc;
                        state_next = FETCH;
                    end
                end else begin
                    // Only a prefetching build can see data while holding.
                    if (accept) begin
                        buf_push = 1'b1;
                        pc_next  = next_pc(pc_reg);
                    end
                    if (!stall) begin
                        data_f_next = '{raw_instr: head_entry.instr,
                                        pc:        head_entry.pc,
                                        is_bubble: 1'b0};
                        buf_pop     = 1'b1;
                        if ((buf_count == BUF_CNT_W'(1)) && !accept) begin
                            state_next = FETCH;
                        end
                    end
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State, pc and decode-word registers; reset drops any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= FETCH;
            pc_reg     <= PCINIT;
            target_reg <= PCINIT;
            data_f_reg <= '{raw_instr: 32'd0, pc: 64'd0, is_bubble: 1'b1};
            req_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
            data_f_reg <= data_f_next;
            req_en_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): sequential streaming, slow
// bus, decode stall/hold, redirects in FETCH/DISCARD/HOLD, pc wrap and reset.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF)
    );

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic drive(input logic dok, input logic [31:0] data, input logic stl,
                         input logic rv, input logic [63:0] rpc);
        iresp.addr_ok  = dok;
        iresp.data_ok  = dok;
        iresp.data     = data;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Advance one cycle; outputs are then sampled mid-cycle at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_req(input string tag, input logic [63:0] addr);
        check_val({tag, "_valid"}, ireq.valid, 1'b1);
        check_val({tag, "_addr"}, ireq.addr, addr);
    endtask

    task automatic chk_word(input string tag, input logic [63:0] pc, input logic [31:0] raw);
        check_val({tag, "_bub"}, dataF.is_bubble, 1'b0);
        check_val({tag, "_pc"}, dataF.pc, pc);
        check_val({tag, "_raw"}, dataF.raw_instr, raw);
    endtask

    task automatic chk_bubble(input string tag);
        check_val({tag, "_bub"}, dataF.is_bubble, 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        @(negedge clk);
        check_val("rst_valid", ireq.valid, 1'b0);
        check_val("rst_bub", dataF.is_bubble, 1'b1);
        check_val("rst_pc", dataF.pc, 64'd0);
        check_val("rst_raw", dataF.raw_instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_req("rel", 64'h8000_0000);

        // Back-to-back data_ok: one word per cycle, one cycle latency.
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("s0", 64'h8000_0000, 32'h13);
        chk_req("s0", 64'h8000_0004);
        step();
        chk_word("s1", 64'h8000_0004, 32'h13);
        step();
        chk_word("s2", 64'h8000_0008, 32'h13);
        chk_req("s2", 64'h8000_000C);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        step();
        chk_bubble("s3");

        // Slow bus: address held for 4 cycles, bubbles until data returns.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk_req($sformatf("slow%0d", i), 64'h8000_0000);
            drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
            step();
            chk_bubble($sformatf("slow%0d", i));
        end
        chk_req("slow3", 64'h8000_0000);
        drive(1'b1, 32'hA0A0_0001, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("slow_w", 64'h8000_0000, 32'hA0A0_0001);

        // Decode stall for two cycles after the word at 0x80000004.
        do_reset();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 64'd0);
        step();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("st_pre", 64'h8000_0004, 32'h22);
        drive(1'b1, 32'h33, 1'b1, 1'b0, 64'd0);
        step();
        chk_word("st_f0", 64'h8000_0004, 32'h22);
        check_val("st_hold_valid", ireq.valid, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        step();
        chk_word("st_f1", 64'h8000_0004, 32'h22);
        check_val("st_hold_valid2", ireq.valid, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("st_rel", 64'h8000_0008, 32'h33);
        chk_req("st_rel", 64'h8000_000C);
        drive(1'b1, 32'h44, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("st_next", 64'h8000_000C, 32'h44);

        // Redirect while 0x80000008 is outstanding: DISCARD then 0x80000100.
        do_reset();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 64'd0);
        step();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 64'd0);
        step();
        chk_req("rd_pre", 64'h8000_0008);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0100);
        step();
        chk_bubble("rd0");
        chk_req("rd0", 64'h8000_0008);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        step();
        chk_req("rd1", 64'h8000_0008);
        chk_bubble("rd1");
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0);
        step();
        chk_bubble("rd_drop");
        chk_req("rd_tgt", 64'h8000_0100);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        step();
        chk_bubble("rd_wait");
        drive(1'b1, 32'h55, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("rd_w", 64'h8000_0100, 32'h55);
        chk_req("rd_w", 64'h8000_0104);

        // Second redirect during DISCARD replaces the pending target.
        drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0400);
        step();
        chk_req("dd0", 64'h8000_0104);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0500);
        step();
        chk_req("dd1", 64'h8000_0104);
        drive(1'b1, 32'h0BAD, 1'b0, 1'b0, 64'd0);
        step();
        chk_req("dd_tgt", 64'h8000_0500);
        chk_bubble("dd_drop");
        drive(1'b1, 32'h66, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("dd_w", 64'h8000_0500, 32'h66);

        // Redirect under stall is ignored; redirect with data_ok is immediate.
        do_reset();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("ig_pre", 64'h8000_0000, 32'h11);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_0200);
        step();
        chk_word("ig_frz", 64'h8000_0000, 32'h11);
        chk_req("ig", 64'h8000_0004);
        drive(1'b1, 32'h22, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("ig_w", 64'h8000_0004, 32'h22);
        chk_req("ig_w", 64'h8000_0008);
        drive(1'b1, 32'hEE, 1'b0, 1'b1, 64'h8000_0300);
        step();
        chk_bubble("rdok");
        chk_req("rdok", 64'h8000_0300);
        drive(1'b1, 32'h77, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("rdok_w", 64'h8000_0300, 32'h77);

        // Misaligned target at the top of the address space wraps to 0x2.
        drive(1'b1, 32'hEE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        chk_req("wrap0", 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1'b1, 32'h88, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("wrap_w", 64'hFFFF_FFFF_FFFF_FFFE, 32'h88);
        chk_req("wrap1", 64'h0000_0000_0000_0002);

        // Redirect while a word sits in HOLD drops it.
        do_reset();
        drive(1'b1, 32'h11, 1'b0, 1'b0, 64'd0);
        step();
        drive(1'b1, 32'h22, 1'b1, 1'b0, 64'd0);
        step();
        check_val("hr_hold_valid", ireq.valid, 1'b0);
        chk_word("hr_frz", 64'h8000_0000, 32'h11);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0600);
        step();
        chk_bubble("hr");
        chk_req("hr", 64'h8000_0600);
        drive(1'b1, 32'h99, 1'b0, 1'b0, 64'd0);
        step();
        chk_word("hr_w", 64'h8000_0600, 32'h99);

        // Reset with a request pending abandons it immediately.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
        check_val("mr_pre_valid", ireq.valid, 1'b1);
        reset = 1'b1;
        #1;
        check_val("mr_valid", ireq.valid, 1'b0);
        chk_bubble("mr");
        @(negedge clk);
        check_val("mr_valid2", ireq.valid, 1'b0);
        chk_bubble("mr2");
        reset = 1'b0;
        step();
        chk_req("mr_rel", 64'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
